unsigned_approx_mul_pipe: RTL
=============================

// Module: unsigned_approx_mul_pipe
// PURPOSE
//  Pipelined, parametrised unsigned WxW multiplier with run-time exact/approximate mode select.
//  Approximate mode keeps rows x[W-1:L] exact and truncates the low-row partial products below column W.
//  Valid/ready streaming on both sides; sits between operand FIFOs and accumulators in the MAC datapath.
// PARAMETERS
//  W      8  operand width (bits); product width is 2*W
//  L      6  approximation level: rows 0..L-1 are truncated in approx mode; legal range 0..W-1
//  TAG_W  4  width of the sideband tag carried alongside each operation
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept the beat
//  in_x       in   W      multiplier; rows are indexed by x bit
//  in_y       in   W      multiplicand
//  in_exact   in   1      1 = exact product, 0 = approximate; sampled per beat
//  in_tag     in   TAG_W  sideband, returned unchanged with the result
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts the result
//  out_z      out  2*W    product
//  out_tag    out  TAG_W  tag of this result
//  out_exact  out  1      mode used for this result
// BEHAVIOUR
//  One clock. Reset is synchronous and active-high.
//  Reset: s1_valid = s2_valid = 0, out_valid = 0, out_z = 0, out_tag = 0, out_exact = 0.
//   in_ready is 1 in the cycle after rst deasserts.
//  Pipeline: stage S1 registers partial-product column sums; stage S2 does the final add (drives the outputs).
//  Latency: exactly 2 cycles from an in_valid&in_ready beat to out_valid, provided there is no backpressure.
//  Handshake:
//   - s2_adv = ~s2_valid | out_ready;  s1_adv = ~s1_valid | s2_adv;  in_ready = s1_adv.
//   - Registered stages only; no combinational path from in_* to out_*.
//   - The only combinational in_ready dependence is on out_ready.
//   - Full throughput: one result per cycle while out_ready = 1.
//   - out_z, out_tag and out_exact hold stable while out_valid & ~out_ready.
//   - No beat is dropped or duplicated under any stall pattern.
//  Arithmetic:
//   - Exact mode: z = x*y, full 2*W bits.
//   - Approx mode: z = ((y * x[W-1:L]) << L) + sum over i<L, j<W with i+j >= W of x[i]&y[j] << (i+j).
//   - All sums are exact in 2*W bits. Approx result <= exact result, and overflow is impossible.
//   - L = 0 makes approx mode identical to exact mode.
//  Mode mixing: in_exact travels with its beat, so consecutive beats may differ in mode with no bubble.
//  Reset mid-operation: all in-flight beats are discarded. No output is produced for them after rst.
//  Simultaneous in-accept and out-consume on a full pipe: both occur and the occupancy is unchanged.
// STRUCTURE
//  Package unsigned_approx_mul_pkg:
//   - default W/L/TAG_W localparams
//   - function keep_mask(W, L, exact) giving the 2-D row/column keep mask for the partial-product array
//  Sub-module approx_pp_gen: combinational W-row masked partial-product generator plus per-column compression to carry-save form.
//   It is instanced in S1. The handshake and pipeline registers stay in the top module.
// TESTING (W=8, L=6)
//  - Exact, x=255 y=255 -> out_z=65025 two cycles later.
//    Approx, same operands -> out_z=63552.
//  - Approx, x=63 y=63 -> 2816 (exact 3969). Approx x=64 y=3 -> 192, which equals exact.
//  - Back-to-back beats alternating exact/approx, tags 0..15, out_ready=1:
//    -> one result per cycle, tags in order, out_exact matches each beat.
//  - Hold out_ready=0 for 5 cycles with 3 beats offered:
//    -> in_ready drops after 2 beats are held, out_z stays stable, then all 3 results drain in order.
//  - rst asserted while 2 beats are in flight:
//    -> out_valid=0 next cycle, no stale result appears, and the next beat has normal 2-cycle latency.
//  - Random 10k beats against a reference model with random valid/ready toggling:
//    -> zero mismatches; approx error <= exact value, and equals 0 for L=0 builds.

Source files
------------

// File: rtl/unsigned_approx_mul_pipe_pkg.sv
// Shared definitions for the approximate multiplier pipeline.
// Provides default parameter values and keep_mask(), which builds the
// row/column keep mask of the partial-product array:
//   bit (row*MAX_W + col) = 1 means x[row]&y[col] contributes at weight row+col.
package unsigned_approx_mul_pkg;

    localparam int unsigned DEF_W     = 8;
    localparam int unsigned DEF_L     = 6;
    localparam int unsigned DEF_TAG_W = 4;

    // Upper bound on W supported by the flattened mask.
    localparam int unsigned MAX_W     = 32;
    localparam int unsigned MASK_BITS = MAX_W * MAX_W;

    typedef logic [MASK_BITS-1:0] keep_mask_t;

    typedef enum logic {
        MODE_APPROX = 1'b0,
        MODE_EXACT  = 1'b1
    } mode_e;

    // Approx mode keeps rows l..w-1 whole; rows below l keep only the
    // partial products landing in column w or above.
    function automatic keep_mask_t keep_mask(input int unsigned w,
                                             input int unsigned l,
                                             input logic        exact);
        keep_mask_t m;
        m = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            for (int unsigned j = 0; j < MAX_W; j++) begin
                if ((i < w) && (j < w) && (exact || (i >= l) || (i + j >= w))) begin
                    m[i*MAX_W + j] = 1'b1;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/unsigned_approx_mul_pipe_pp_gen.sv
// approx_pp_gen: combinational masked partial-product generator.
// Builds the W rows of x[i]&y[j] (masked by mode) and compresses them with a
// linear chain of 3:2 carry-save adders into a redundant sum/carry pair.
// Ports:
//   x, y   : W-bit operands (rows indexed by x bit)
//   exact  : 1 = full array, 0 = truncated low rows
//   sum    : 2*W-bit carry-save sum vector
//   carry  : 2*W-bit carry-save carry vector; sum + carry = product (mod 2^(2W))
module approx_pp_gen
    import unsigned_approx_mul_pkg::*;
#(
    parameter int unsigned W = DEF_W,
    parameter int unsigned L = DEF_L
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           exact,
    output logic [2*W-1:0] sum,
    output logic [2*W-1:0] carry
);

    localparam keep_mask_t KEEP_EXACT  = keep_mask(W, L, 1'b1);
    localparam keep_mask_t KEEP_APPROX = keep_mask(W, L, 1'b0);

    logic [2*W-1:0] pp;
    logic [2*W-1:0] s;
    logic [2*W-1:0] c;
    logic [2*W-1:0] t;

    // Carries out of bit 2W-1 are dropped: the true total always fits in 2W bits,
    // so the modular sum of the redundant pair is still exact.
    always_comb begin
        pp = '0;
        s  = '0;
        c  = '0;
        t  = '0;
        for (int unsigned i = 0; i < W; i++) begin
            pp = '0;
            for (int unsigned j = 0; j < W; j++) begin
                if (exact ? KEEP_EXACT[i*MAX_W + j] : KEEP_APPROX[i*MAX_W + j]) begin
                    pp[i + j] = x[i] & y[j];
                end
            end
            t = s ^ c ^ pp;
            c = ((s & c) | (s & pp) | (c & pp)) << 1;
            s = t;
        end
        sum   = s;
        carry = c;
    end

endmodule

// File: rtl/unsigned_approx_mul_pipe.sv
// unsigned_approx_mul_pipe: two-stage pipelined WxW unsigned multiplier with a
// per-beat exact/approximate mode and a sideband tag.
//   S1 registers the carry-save pair from approx_pp_gen; S2 does the final add
//   and drives the outputs directly from flops.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   in_valid/in_ready                 : operand handshake
//   in_x, in_y, in_exact, in_tag      : operands, mode, sideband
//   out_valid/out_ready               : result handshake
//   out_z, out_tag, out_exact         : product, tag, mode used
module unsigned_approx_mul_pipe
    import unsigned_approx_mul_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned L     = DEF_L,
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_exact,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_exact
);

    logic [2*W-1:0]   pp_sum;
    logic [2*W-1:0]   pp_carry;

    logic             s1_valid_q, s1_valid_d;
    logic [2*W-1:0]   s1_sum_q,   s1_sum_d;
    logic [2*W-1:0]   s1_carry_q, s1_carry_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic             s1_exact_q, s1_exact_d;

    logic             s2_valid_q, s2_valid_d;
    logic [2*W-1:0]   s2_z_q,     s2_z_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
    logic             s2_exact_q, s2_exact_d;

    logic             s1_adv;
    logic             s2_adv;

    approx_pp_gen #(
        .W (W),
        .L (L)
    ) u_pp_gen (
        .x     (in_x),
        .y     (in_y),
        .exact (in_exact),
        .sum   (pp_sum),
        .carry (pp_carry)
    );

    always_comb begin
        s2_adv     = ~s2_valid_q | out_ready;
        s1_adv     = ~s1_valid_q | s2_adv;

        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_carry_d = s1_carry_q;
        s1_tag_d   = s1_tag_q;
        s1_exact_d = s1_exact_q;

        s2_valid_d = s2_valid_q;
        s2_z_d     = s2_z_q;
        s2_tag_d   = s2_tag_q;
        s2_exact_d = s2_exact_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sum_d   = pp_sum;
                s1_carry_d = pp_carry;
                s1_tag_d   = in_tag;
                s1_exact_d = in_exact;
            end
        end

        // Payload only moves on a real beat so outputs stay put while stalled.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_z_d     = s1_sum_q + s1_carry_q;
                s2_tag_d   = s1_tag_q;
                s2_exact_d = s1_exact_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_carry_q <= '0;
            s1_tag_q   <= '0;
            s1_exact_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_z_q     <= '0;
            s2_tag_q   <= '0;
            s2_exact_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_carry_q <= s1_carry_d;
            s1_tag_q   <= s1_tag_d;
            s1_exact_q <= s1_exact_d;
            s2_valid_q <= s2_valid_d;
            s2_z_q     <= s2_z_d;
            s2_tag_q   <= s2_tag_d;
            s2_exact_q <= s2_exact_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_z     = s2_z_q;
    assign out_tag   = s2_tag_q;
    assign out_exact = s2_exact_q;

endmodule
